// File: rtl/port_map_pipe_if.sv
// Handshake and data bundle between decode, KMEM and the DSP48E port C operand muxes.
interface port_map_pipe_if #(
  parameter int TYPE_W  = 3,
  parameter int SEL_W   = 2,
  parameter int KADDR_W = 8,
  parameter int KDATA_W = 16
);
  logic               IN_VALID;
  logic               IN_READY;
  logic [TYPE_W-1:0]  INSTR_TYPE;
  logic [KDATA_W-1:0] IMM_IN;
  logic [KADDR_W-1:0] KADDR_IN;
  logic               KMEM_RE;
  logic [KADDR_W-1:0] KMEM_ADDR;
  logic [KDATA_W-1:0] KMEM_DATA;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [SEL_W-1:0]   IMM_SEL;
  logic [KDATA_W-1:0] IMM_OUT;
  logic               MEM_OP;
  logic               ILLEGAL;

  modport slave (
    input  IN_VALID, INSTR_TYPE, IMM_IN, KADDR_IN, KMEM_DATA, OUT_READY,
    output IN_READY, KMEM_RE, KMEM_ADDR, OUT_VALID, IMM_SEL, IMM_OUT, MEM_OP, ILLEGAL
  );

  modport master (
    output IN_VALID, INSTR_TYPE, IMM_IN, KADDR_IN, KMEM_DATA, OUT_READY,
    input  IN_READY, KMEM_RE, KMEM_ADDR, OUT_VALID, IMM_SEL, IMM_OUT, MEM_OP, ILLEGAL
  );
endinterface

// File: rtl/port_map_pipe.sv
// Pipelined INSTR_TYPE -> IMM_SEL mapper with KMEM read sequencing for RK instructions.
// Define IPPRO_PMAP_PERF_EN to add the PERF_STALL / PERF_RK saturating counters.
module port_map_pipe #(
  parameter int TYPE_W   = 3,
  parameter int SEL_W    = 2,
  parameter int KADDR_W  = 8,
  parameter int KDATA_W  = 16,
  parameter int KMEM_LAT = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  port_map_pipe_if.slave bus
`ifdef IPPRO_PMAP_PERF_EN
  ,
  output logic [15:0]    PERF_STALL,
  output logic [15:0]    PERF_RK
`endif
);

  localparam logic [TYPE_W-1:0] TYPE_RR  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] TYPE_RI  = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] TYPE_MEM = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] TYPE_RK  = TYPE_W'(3);

  typedef enum logic [1:0] {IDLE, KWAIT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [SEL_W-1:0]   imm_sel_q, imm_sel_d;
  logic [KDATA_W-1:0] imm_out_q, imm_out_d;
  logic               mem_op_q, mem_op_d;
  logic               illegal_q, illegal_d;

  logic in_ready;
  logic xfer;
  logic is_rk;
  logic kmem_re;

  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || bus.OUT_READY);
    xfer     = bus.IN_VALID && in_ready;
    is_rk    = (bus.INSTR_TYPE == TYPE_RK);
    kmem_re  = xfer && is_rk;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    imm_sel_d   = imm_sel_q;
    imm_out_d   = imm_out_q;
    mem_op_d    = mem_op_q;
    illegal_d   = illegal_q;
    case (state_q)
      IDLE: begin
        if (out_valid_q && bus.OUT_READY) out_valid_d = 1'b0;
        if (xfer) begin
          if (is_rk) begin
            state_d = KWAIT;
            cnt_d   = 3'(KMEM_LAT);
          end else begin
            // A same-cycle drain and accept simply overwrites the output register.
            out_valid_d = 1'b1;
            imm_sel_d   = '0;
            imm_out_d   = '0;
            mem_op_d    = 1'b0;
            illegal_d   = 1'b0;
            case (bus.INSTR_TYPE)
              TYPE_RR:  ;
              TYPE_RI: begin
                imm_sel_d = SEL_W'(1);
                imm_out_d = bus.IMM_IN;
              end
              TYPE_MEM: mem_op_d  = 1'b1;
              default:  illegal_d = 1'b1;
            endcase
          end
        end
      end
      KWAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Count of 1 marks the cycle in which KMEM_DATA is valid.
        if (cnt_q == 3'd1) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          imm_sel_d   = SEL_W'(2);
          imm_out_d   = bus.KMEM_DATA;
          mem_op_d    = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      HOLD: begin
        if (bus.OUT_READY) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      imm_sel_q   <= '0;
      imm_out_q   <= '0;
      mem_op_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      imm_sel_q   <= imm_sel_d;
      imm_out_q   <= imm_out_d;
      mem_op_q    <= mem_op_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.KMEM_RE   = kmem_re;
  assign bus.KMEM_ADDR = kmem_re ? bus.KADDR_IN : '0;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.IMM_SEL   = imm_sel_q;
  assign bus.IMM_OUT   = imm_out_q;
  assign bus.MEM_OP    = mem_op_q;
  assign bus.ILLEGAL   = illegal_q;

`ifdef IPPRO_PMAP_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_rk_q, perf_rk_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_rk_d    = perf_rk_q;
    if (bus.IN_VALID && !in_ready && (perf_stall_q != 16'hFFFF)) perf_stall_d = perf_stall_q + 16'd1;
    if (kmem_re && (perf_rk_q != 16'hFFFF)) perf_rk_d = perf_rk_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      perf_stall_q <= '0;
      perf_rk_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_rk_q    <= perf_rk_d;
    end
  end

  assign PERF_STALL = perf_stall_q;
  assign PERF_RK    = perf_rk_q;
`endif

endmodule

// File: tb/tb_port_map_pipe.sv
// Self-checking bench for port_map_pipe: directed scenarios plus randomized traffic against a cycle-level model.
module tb_port_map_pipe;
  localparam int LAT = 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  port_map_pipe_if #(.TYPE_W(3), .SEL_W(2), .KADDR_W(8), .KDATA_W(16)) bus ();

`ifdef IPPRO_PMAP_PERF_EN
  logic [15:0] perf_stall, perf_rk;
`endif

  port_map_pipe #(.TYPE_W(3), .SEL_W(2), .KADDR_W(8), .KDATA_W(16), .KMEM_LAT(LAT)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
`ifdef IPPRO_PMAP_PERF_EN
    ,
    .PERF_STALL(perf_stall),
    .PERF_RK   (perf_rk)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  longint cyc = 0;

  logic [15:0] kmem [256];
  bit          ksched_v [8];
  logic [15:0] ksched_d [8];

  // Model of the visible output register and the in-flight RK request
  bit          m_ov   = 0;
  logic [1:0]  m_sel  = 0;
  logic [15:0] m_imm  = 0;
  bit          m_mem  = 0;
  bit          m_ill  = 0;
  bit          m_busy = 0;
  longint      m_due  = -1;
  int          m_stall = 0;
  int          m_rk    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_ready();
    return !m_busy && (!m_ov || bus.OUT_READY);
  endfunction

  task automatic map_type(input logic [2:0] t, input logic [15:0] imm,
                          output logic [1:0] sel, output logic [15:0] o,
                          output bit mem, output bit ill);
    sel = 2'b00; o = 16'h0; mem = 0; ill = 0;
    if (t == 3'd1) begin sel = 2'b01; o = imm; end
    else if (t == 3'd2) mem = 1;
    else if (t != 3'd0) ill = 1;
  endtask

  task automatic tick();
    bit rdy, acc, re;
    logic [7:0]  addr;
    logic [15:0] kd;
    @(negedge CLK);
    rdy  = exp_ready();
    acc  = bus.IN_VALID && rdy;
    re   = acc && (bus.INSTR_TYPE == 3'd3);
    addr = bus.KADDR_IN;
    kd   = bus.KMEM_DATA;
    chk("in_ready",  bus.IN_READY,  rdy);
    chk("kmem_re",   bus.KMEM_RE,   re);
    chk("kmem_addr", bus.KMEM_ADDR, re ? addr : 8'h00);
    chk("out_valid", bus.OUT_VALID, m_ov);
    if (m_ov) begin
      chk("imm_sel", bus.IMM_SEL, m_sel);
      chk("imm_out", bus.IMM_OUT, m_imm);
      chk("mem_op",  bus.MEM_OP,  m_mem);
      chk("illegal", bus.ILLEGAL, m_ill);
    end
`ifdef IPPRO_PMAP_PERF_EN
    chk("perf_stall", perf_stall, m_stall);
    chk("perf_rk",    perf_rk,    m_rk);
`endif
    if (!RST_N) begin
      m_ov = 0; m_sel = 0; m_imm = 0; m_mem = 0; m_ill = 0;
      m_busy = 0; m_due = -1; m_stall = 0; m_rk = 0;
    end else begin
      if (bus.IN_VALID && !rdy && m_stall < 65535) m_stall++;
      if (re && m_rk < 65535) m_rk++;
      if (m_ov && bus.OUT_READY) begin
        m_ov = 0;
        if (m_busy) m_busy = 0;
      end
      if (m_busy && cyc == m_due) begin
        m_ov = 1; m_sel = 2'b10; m_imm = kd; m_mem = 0; m_ill = 0;
      end
      if (acc) begin
        if (bus.INSTR_TYPE == 3'd3) begin
          m_busy = 1;
          m_due  = cyc + LAT;
        end else begin
          map_type(bus.INSTR_TYPE, bus.IMM_IN, m_sel, m_imm, m_mem, m_ill);
          m_ov = 1;
        end
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    for (int i = 0; i < 7; i++) begin
      ksched_v[i] = ksched_v[i+1];
      ksched_d[i] = ksched_d[i+1];
    end
    ksched_v[7] = 0;
    if (re) begin
      ksched_v[LAT-1] = 1;
      ksched_d[LAT-1] = kmem[addr];
    end
    bus.KMEM_DATA = ksched_v[0] ? ksched_d[0] : 16'($urandom);
  endtask

  initial begin
    logic [2:0]  t1_type [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
    logic [15:0] t1_imm  [4] = '{16'hFFFF, 16'h00A5, 16'hFFFF, 16'hFFFF};
    logic [1:0]  t1_sel  [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
    logic [15:0] t1_out  [4] = '{16'h0000, 16'h00A5, 16'h0000, 16'h0000};
    bit          t1_mem  [4] = '{0, 0, 1, 0};
    bit          t1_ill  [4] = '{0, 0, 0, 1};

    for (int i = 0; i < 256; i++) kmem[i] = 16'($urandom);
    kmem[8'h3C] = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin ksched_v[i] = 0; ksched_d[i] = 0; end

    bus.IN_VALID = 0; bus.INSTR_TYPE = 0; bus.IMM_IN = 0; bus.KADDR_IN = 0;
    bus.KMEM_DATA = 16'h1357; bus.OUT_READY = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", bus.OUT_VALID, 0);
    chk("rst_imm_sel",   bus.IMM_SEL,   0);
    chk("rst_imm_out",   bus.IMM_OUT,   0);
    chk("rst_mem_op",    bus.MEM_OP,    0);
    chk("rst_illegal",   bus.ILLEGAL,   0);
    chk("rst_kmem_re",   bus.KMEM_RE,   0);
    RST_N = 1;

    // RR / RI / MEM / illegal stream, one per cycle
    for (int i = 0; i < 4; i++) begin
      bus.IN_VALID = 1; bus.INSTR_TYPE = t1_type[i]; bus.IMM_IN = t1_imm[i];
      #1 chk("t1_in_ready", bus.IN_READY, 1);
      tick();
      chk("t1_out_valid", bus.OUT_VALID, 1);
      chk("t1_imm_sel",   bus.IMM_SEL,   t1_sel[i]);
      chk("t1_imm_out",   bus.IMM_OUT,   t1_out[i]);
      chk("t1_mem_op",    bus.MEM_OP,    t1_mem[i]);
      chk("t1_illegal",   bus.ILLEGAL,   t1_ill[i]);
    end
    bus.IN_VALID = 0;
    tick();

    // RK at address 3C
    bus.IN_VALID = 1; bus.INSTR_TYPE = 3'd3; bus.KADDR_IN = 8'h3C;
    #1 chk("t2_kmem_re", bus.KMEM_RE, 1);
    chk("t2_kmem_addr", bus.KMEM_ADDR, 8'h3C);
    tick();
    bus.IN_VALID = 0;
    #1 chk("t2_in_ready_w1", bus.IN_READY, 0);
    tick();
    #1 chk("t2_in_ready_w2", bus.IN_READY, 0);
    chk("t2_no_early_valid", bus.OUT_VALID, 0);
    tick();
    chk("t2_out_valid", bus.OUT_VALID, 1);
    chk("t2_imm_sel",   bus.IMM_SEL,   2'b10);
    chk("t2_imm_out",   bus.IMM_OUT,   16'hBEEF);
    tick();

    // Backpressure after an RI accept
    bus.OUT_READY = 0; bus.IN_VALID = 1; bus.INSTR_TYPE = 3'd1; bus.IMM_IN = 16'h1234;
    tick();
    bus.INSTR_TYPE = 3'd0; bus.IMM_IN = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_in_ready", bus.IN_READY, 0);
      chk("t3_hold_valid", bus.OUT_VALID, 1);
      chk("t3_hold_imm",   bus.IMM_OUT,   16'h1234);
      tick();
    end
    bus.OUT_READY = 1;
    #1 chk("t3_release_ready", bus.IN_READY, 1);
    tick();
    chk("t3_next_valid", bus.OUT_VALID, 1);
    chk("t3_next_sel",   bus.IMM_SEL,   2'b00);
    chk("t3_next_imm",   bus.IMM_OUT,   16'h0000);
    bus.IN_VALID = 0;
    tick();

    // Reset one cycle into a KMEM wait
    bus.IN_VALID = 1; bus.INSTR_TYPE = 3'd3; bus.KADDR_IN = 8'h55;
    tick();
    bus.IN_VALID = 0;
    RST_N = 0;
    tick();
    RST_N = 1;
    chk("t4_out_valid", bus.OUT_VALID, 0);
    chk("t4_imm_sel",   bus.IMM_SEL,   0);
    chk("t4_imm_out",   bus.IMM_OUT,   0);
    chk("t4_mem_op",    bus.MEM_OP,    0);
    chk("t4_illegal",   bus.ILLEGAL,   0);
    chk("t4_in_ready",  bus.IN_READY,  1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_late_data", bus.OUT_VALID, 0);
    end

    // Concurrent drain and accept
    bus.IN_VALID = 1; bus.INSTR_TYPE = 3'd0; bus.OUT_READY = 0;
    tick();
    bus.INSTR_TYPE = 3'd1; bus.IMM_IN = 16'h5A5A; bus.OUT_READY = 1;
    #1 chk("t5_in_ready", bus.IN_READY, 1);
    tick();
    chk("t5_out_valid", bus.OUT_VALID, 1);
    chk("t5_imm_sel",   bus.IMM_SEL,   2'b01);
    chk("t5_imm_out",   bus.IMM_OUT,   16'h5A5A);
    bus.IN_VALID = 0;
    tick();

`ifdef IPPRO_PMAP_PERF_EN
    // Three back-to-back RK, then one RR, with IN_VALID held high
    RST_N = 0;
    tick();
    RST_N = 1;
    bus.OUT_READY = 1;
    for (int i = 0; i < 4; i++) begin
      bit acc;
      int guard;
      bus.IN_VALID = 1; bus.INSTR_TYPE = (i < 3) ? 3'd3 : 3'd0; bus.KADDR_IN = 8'(i);
      guard = 0;
      do begin
        acc = exp_ready();
        tick();
        guard++;
      end while (!acc && guard < 20);
      chk("t6_accept", acc, 1);
    end
    bus.IN_VALID = 0;
    chk("t6_perf_rk",    perf_rk,    16'd3);
    chk("t6_perf_stall", perf_stall, 16'd9);
    tick();
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      RST_N          = ($urandom_range(0, 299) != 0);
      bus.IN_VALID   = ($urandom_range(0, 9) < 7);
      bus.INSTR_TYPE = ($urandom_range(0, 9) < 3) ? 3'd3 : 3'($urandom_range(0, 7));
      bus.IMM_IN     = 16'($urandom);
      bus.KADDR_IN   = 8'($urandom);
      bus.OUT_READY  = ($urandom_range(0, 3) != 0);
      tick();
    end
    RST_N = 1; bus.IN_VALID = 0; bus.OUT_READY = 1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
